// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_sub_fs1.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module serial_sub_fs1 (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b over WIDTH cycles, LSB first,
// using one full-subtractor cell and a registered borrow, with start/busy/done handshake.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sb_q, res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             br_q, bout_q;
   logic             accept, lastBit;
   logic             cellD, cellB;

   // New operands may only be taken when no operation is in flight.
   assign accept  = (state_q != RUN) && start;
   assign lastBit = (state_q == RUN) && (cnt_q == CNT_LAST);

   serial_sub_fs1 u_fs1 (
      .a_i    (sa_q[0]),
      .b_i    (sb_q[0]),
      .bin_i  (br_q),
      .d_o    (cellD),
      .bout_o (cellB)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // The reported borrow is captured only on the final bit so it stays stable outside RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q   <= '0;
         sb_q   <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
         br_q   <= 1'b0;
         bout_q <= 1'b0;
      end else if (accept) begin
         sa_q  <= a;
         sb_q  <= b;
         br_q  <= 1'b0;
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         sa_q  <= sa_q >> 1;
         sb_q  <= sb_q >> 1;
         res_q <= {cellD, res_q[WIDTH-1:1]};
         br_q  <= cellB;
         cnt_q <= cnt_q + CNT_W'(1);
         if (lastBit) begin
            bout_q <= cellB;
         end
      end
   end

   assign diff = res_q;
   assign bout = bout_q;

endmodule
